// File: rtl/spi_pkg.sv
// Shared SPI master types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  localparam int SPI_WIDTH = 8;
  localparam int NUM_SS    = 2;
  localparam logic [NUM_SS-1:0] SS_IDLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/SPIbus.sv
// Serial-side SPI bundle (mode 0, active-low selects).
// Latency: n/a (wires only).
// Backpressure: none; the serial bus is fully master-timed.
interface SPIbus;
  import spi_pkg::*;

  logic              miso;
  logic              mosi;
  logic              sck;
  logic [NUM_SS-1:0] ss;

  modport Master (
    input  miso,
    output mosi, sck, ss
  );
endinterface

// File: rtl/SPIctrl.sv
// System-side control bundle of the SPI master.
// Latency: n/a (wires only).
// Backpressure: XmitFull tells the producer that a strobe would be dropped.
interface SPIctrl;
  import spi_pkg::*;

  logic [SPI_WIDTH-1:0] toXmit;
  logic                 strobe;
  logic [NUM_SS-1:0]    ss;
  logic [SPI_WIDTH-1:0] Rcvd;
  logic                 Ready;
  logic                 XmitFull;
  logic                 busy;

  modport Master (
    input  toXmit, strobe, ss,
    output Rcvd, Ready, XmitFull, busy
  );
endinterface

// File: rtl/spi_sck_divider.sv
// Half-period tick generator: o_tick marks the last clk of each CLK_DIV-cycle phase.
// Latency: tick asserted CLK_DIV-1 cycles after a restart.
// Backpressure: none; i_restart realigns the count on every FSM state entry.
module spi_sck_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam logic [7:0] LP_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  assign o_tick = (r_cnt == LP_LAST);

  // Count clk cycles within the current phase; wrap on tick, zero on restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, 8-bit frames, one-entry transmit holding buffer.
// Latency: strobe-to-Ready 2 + 16*CLK_DIV clk; back-to-back frames separated by CLK_DIV clk of ss high.
// Backpressure: XmitFull=1 while a byte waits; strobes seen while full are dropped.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic   clk,
  input  logic   reset,
  SPIctrl.Master ctrl,
  SPIbus.Master  bus
);

  localparam logic [3:0] LP_BITS = 4'(SPI_WIDTH);

  spi_state_e           r_state, w_next;
  logic [SPI_WIDTH-1:0] r_buf, r_tx, r_rx, r_rcvd;
  logic [NUM_SS-1:0]    r_mask, r_ss;
  logic                 r_full, r_sck, r_mosi, r_ready;
  logic [3:0]           r_bit_cnt;
  logic                 w_tick, w_restart, w_accept;
  logic                 w_load, w_enter_high, w_enter_low, w_finish;

  assign w_accept  = ctrl.strobe & ~r_full;
  assign w_restart = (w_next != r_state);

  spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .reset     (reset),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Next state plus one-cycle transition strobes that steer the datapath
  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_enter_high = 1'b0;
    w_enter_low  = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full) begin
          w_next = ST_SETUP;
          w_load = 1'b1;
        end
      end
      ST_SETUP, ST_LOW: begin
        if (w_tick) begin
          w_next       = ST_HIGH;
          w_enter_high = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_tick) begin
          if (r_bit_cnt == LP_BITS) begin
            w_next   = ST_GAP;
            w_finish = 1'b1;
          end else begin
            w_next      = ST_LOW;
            w_enter_low = 1'b1;
          end
        end
      end
      ST_GAP: begin
        // A byte queued during the frame starts right here, skipping IDLE
        if (w_tick) begin
          if (r_full) begin
            w_next = ST_SETUP;
            w_load = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Holding buffer: fills only when empty, drains when a frame starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf  <= '0;
      r_mask <= '0;
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_buf  <= ctrl.toXmit;
      r_mask <= ctrl.ss;
      r_full <= 1'b1;
    end else if (w_load) begin
      r_buf  <= '0;
      r_mask <= '0;
      r_full <= 1'b0;
    end
  end

  // Serial engine: sck, mosi, selects, shift registers and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss      <= SS_IDLE;
    end else begin
      if (w_load) begin
        r_tx      <= r_buf;
        r_mosi    <= r_buf[SPI_WIDTH-1];
        r_ss      <= ~r_mask;
        r_sck     <= 1'b0;
        r_bit_cnt <= '0;
      end
      if (w_enter_high) begin
        r_sck     <= 1'b1;
        r_rx      <= {r_rx[SPI_WIDTH-2:0], bus.miso};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_enter_low) begin
        r_sck  <= 1'b0;
        r_mosi <= r_tx[SPI_WIDTH-2];
        r_tx   <= r_tx << 1;
      end
      if (w_finish) begin
        r_sck <= 1'b0;
        r_ss  <= SS_IDLE;
      end
    end
  end

  // Frame completion: publish received byte and pulse Ready once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rcvd  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= w_finish;
      if (w_finish) r_rcvd <= r_rx;
    end
  end

  assign ctrl.Rcvd     = r_rcvd;
  assign ctrl.Ready    = r_ready;
  assign ctrl.XmitFull = r_full;
  assign ctrl.busy     = (r_state != ST_IDLE);
  assign bus.mosi      = r_mosi;
  assign bus.sck       = r_sck;
  assign bus.ss        = r_ss;

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench for spi_master with a timeline reference model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_spi_master;
  import spi_pkg::*;

  localparam int D     = 2;
  localparam int FRAME = 16 * D;   // SETUP edge to Ready edge
  localparam int SPAN  = 17 * D;   // SETUP edge to end of GAP

  // One accepted byte: clk edge it was loaded, clk edge its frame starts
  typedef struct { int load; int start; logic [7:0] tx; logic [1:0] mask; logic [7:0] rx; } frame_t;
  typedef struct { logic [7:0] tx; logic [7:0] rx; logic [1:0] ss; int ready; } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  frame_t fr[$];
  exp_t   exp_q[$];
  logic [7:0] slave_mem [0:255];
  int   neg_cnt = 0;
  int   neg_base = 0;
  int   mon_rises = 0;
  logic [7:0] mon_cap = '0;
  logic [1:0] mon_ss = '0;
  logic prev_sck = 1'b0;

  SPIctrl ctrl();
  SPIbus  bus();
  SPIctrl ctrl1();
  SPIbus  bus1();

  spi_master #(.CLK_DIV(D)) dut  (.clk(clk), .reset(reset), .ctrl(ctrl),  .bus(bus));
  spi_master #(.CLK_DIV(1)) dut1 (.clk(clk), .reset(reset), .ctrl(ctrl1), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Slave model: each frame shifts out its byte MSB first, changing after sck falls
  always @(negedge bus.sck) neg_cnt <= neg_cnt + 1;
  initial begin
    int idx;
    bus.miso = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      idx = neg_cnt - neg_base;
      bus.miso = slave_mem[(idx / 8) % 256][7 - (idx % 8)];
    end
  end

  // Issue one strobe; the model decides acceptance and frame timing from the rules
  task automatic send(input logic [7:0] tx, input logic [1:0] ss, input logic [7:0] rx);
    frame_t f;
    exp_t   e;
    int     u;
    u = cyc + 1;  // edge at which the DUT samples this strobe
    ctrl.toXmit = tx;
    ctrl.ss     = ss;
    ctrl.strobe = 1'b1;
    if (fr.size() == 0 || u > fr[$].start) begin
      f.load  = u;
      f.start = u + 1;
      if (fr.size() != 0 && fr[$].start + SPAN > f.start) f.start = fr[$].start + SPAN;
      f.tx = tx; f.mask = ss; f.rx = rx;
      slave_mem[fr.size()] = rx;
      fr.push_back(f);
      e.tx = tx; e.rx = rx; e.ss = ~ss; e.ready = f.start + FRAME;
      exp_q.push_back(e);
    end
    step(1);
    ctrl.strobe = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (fr.size() != 0 && cyc < fr[$].start + SPAN + 1 && w < 3000) begin
      step(1);
      w++;
    end
    check("drain_pending_frames", exp_q.size(), 0);
  endtask

  // Per-cycle expectations derived from frame start times with plain arithmetic
  function automatic void model_check(input int n);
    logic e_full, e_busy, e_sck, e_mosi, e_ready;
    logic [1:0] e_ss;
    logic [7:0] e_rcvd;
    int o;
    e_full = 0; e_busy = 0; e_sck = 0; e_mosi = 0; e_ready = 0; e_ss = 2'b11; e_rcvd = 8'h00;
    foreach (fr[i]) begin
      o = n - fr[i].start;
      if (n >= fr[i].load && n < fr[i].start) e_full = 1;
      if (o >= 0 && o < SPAN) e_busy = 1;
      if (o >= 0 && o < FRAME) begin
        e_ss   = ~fr[i].mask;
        e_sck  = ((o / D) % 2) == 1;
        e_mosi = fr[i].tx[7 - o / (2 * D)];
      end else if (o >= FRAME) begin
        e_mosi = fr[i].tx[0];
        e_rcvd = fr[i].rx;
      end
      if (o == FRAME) e_ready = 1;
    end
    check("xmitfull", ctrl.XmitFull, e_full);
    check("busy", ctrl.busy, e_busy);
    check("bus_ss", bus.ss, e_ss);
    check("sck", bus.sck, e_sck);
    check("mosi", bus.mosi, e_mosi);
    check("ready", ctrl.Ready, e_ready);
    check("rcvd", ctrl.Rcvd, e_rcvd);
  endfunction

  // Monitor: per-cycle model checks, bit capture on sck rises, scoreboard pop on Ready
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      model_check(cyc);
      if (reset) begin
        mon_rises = 0;
        prev_sck  = 1'b0;
      end else begin
        if (bus.sck && !prev_sck) begin
          mon_cap = {mon_cap[6:0], bus.mosi};
          mon_ss  = bus.ss;
          mon_rises++;
        end
        prev_sck = bus.sck;
        if (ctrl.Ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ready", ctrl.Ready, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("sb_rcvd", ctrl.Rcvd, e.rx);
            check("sb_mosi_byte", mon_cap, e.tx);
            check("sb_sck_rises", mon_rises, 8);
            check("sb_ss_in_frame", mon_ss, e.ss);
            check("sb_ready_cycle", cyc, e.ready);
          end
          mon_rises = 0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int w, t0, lat, bad, r1;
    logic p1;
    ctrl.strobe = 1'b0; ctrl.toXmit = '0; ctrl.ss = '0;
    ctrl1.strobe = 1'b0; ctrl1.toXmit = '0; ctrl1.ss = '0; bus1.miso = 1'b1;
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    neg_base = neg_cnt;
    reset = 1'b0;
    step(2);
    check("reset_rcvd", ctrl.Rcvd, 8'h00);
    check("reset_ss", bus.ss, 2'b11);
    check("reset_busy", ctrl.busy, 1'b0);

    // Single directed frame, then a held byte plus a dropped third strobe
    send(8'hA5, 2'b01, 8'h3C);
    drain();
    send(8'h11, 2'b10, 8'h96);
    step(5);
    send(8'h22, 2'b01, 8'h69);
    step(3);
    send(8'h33, 2'b11, 8'hE7);
    drain();

    // Randomized strobes with random spacing, including strobes while full
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 40));
      send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    drain();

    // Reset after the 4th sck rise of a frame
    send(8'h5A, 2'b10, 8'hC3);
    w = 0;
    while (mon_rises < 4 && w < 300) begin
      step(1);
      w++;
    end
    check("rst_reached_4th_rise", mon_rises >= 4, 1'b1);
    #2;
    reset = 1'b1;
    fr.delete();
    exp_q.delete();
    #1;
    check("midrst_sck", bus.sck, 1'b0);
    check("midrst_ss", bus.ss, 2'b11);
    check("midrst_busy", ctrl.busy, 1'b0);
    check("midrst_rcvd", ctrl.Rcvd, 8'h00);
    check("midrst_ready", ctrl.Ready, 1'b0);
    check("midrst_xmitfull", ctrl.XmitFull, 1'b0);
    check("midrst_mosi", bus.mosi, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    neg_base = neg_cnt;
    reset = 1'b0;
    step(100);
    send(8'($urandom_range(0, 255)), 2'b01, 8'($urandom_range(0, 255)));
    drain();

    // CLK_DIV=1 instance: no slave selected, miso held high
    t0 = cyc;
    ctrl1.toXmit = 8'hFF; ctrl1.ss = 2'b00; ctrl1.strobe = 1'b1;
    step(1);
    ctrl1.strobe = 1'b0;
    lat = -1; bad = 0; r1 = 0; p1 = 1'b0;
    w = 0;
    while (lat < 0 && w < 60) begin
      if (bus1.ss !== 2'b11) bad++;
      if (bus1.sck && !p1) r1++;
      p1 = bus1.sck;
      if (ctrl1.Ready) lat = cyc - t0;
      else step(1);
      w++;
    end
    check("div1_latency", lat, 18);
    check("div1_rcvd", ctrl1.Rcvd, 8'hFF);
    check("div1_ss_never_low", bad, 0);
    check("div1_sck_rises", r1, 8);

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
